// File: rtl/param_stream_loader_if.sv
// param_stream_loader_if
//   Groups the descriptor handshake, the external parameter-memory read port
//   and the shared CiM bus drive signals of param_stream_loader.
//
//   Handshake semantics (descriptor channel): a descriptor transfers on a
//   rising clock edge where seg_valid and seg_ready are both high. The source
//   holds seg_valid and every seg_* field stable until that edge. seg_ready
//   does not depend on seg_valid. Every other channel here is a plain strobe:
//   ext_mem_rd and bus_drive are single-cycle requests with no back-pressure.
//   ext_mem_data_valid qualifies ext_mem_data for one cycle.
//
//   Modports:
//     master : the loader (drives seg_ready/seg_done, memory read, bus outputs)
//     slave  : the environment (master FSM, external memory, CiM bus)
//
//   Optional: with PARAM_STREAM_CHECKSUM_EN defined, seg_checksum is added.
interface param_stream_loader_if #(
  parameter int NUM_CIMS     = 64,
  parameter int N_STORAGE    = 16,
  parameter int WORDS_PER_OP = 3,
  parameter int ADDR_W       = 15,
  parameter int LEN_W        = 8,
  parameter int BUS_OP_WIDTH = 4
);
  localparam int CW = $clog2(NUM_CIMS);

  logic                              seg_valid;
  logic                              seg_ready;
  logic [ADDR_W-1:0]                 seg_base_addr;
  logic [LEN_W-1:0]                  seg_len;
  logic [CW:0]                       seg_num_cims;
  logic [LEN_W-1:0]                  seg_cim_addr;
  logic                              seg_done;
  logic                              ext_mem_rd;
  logic [ADDR_W-1:0]                 ext_mem_addr;
  logic                              ext_mem_data_valid;
  logic [N_STORAGE-1:0]              ext_mem_data;
  logic                              bus_ready;
  logic                              bus_drive;
  logic [BUS_OP_WIDTH-1:0]           bus_op_write;
  logic [WORDS_PER_OP*N_STORAGE-1:0] bus_data_write;
  logic [CW-1:0]                     bus_target_write;
`ifdef PARAM_STREAM_CHECKSUM_EN
  logic [N_STORAGE+LEN_W+CW-1:0]     seg_checksum;

  modport master (
    input  seg_valid, seg_base_addr, seg_len, seg_num_cims, seg_cim_addr,
    input  ext_mem_data_valid, ext_mem_data, bus_ready,
    output seg_ready, seg_done, ext_mem_rd, ext_mem_addr,
    output bus_drive, bus_op_write, bus_data_write, bus_target_write,
    output seg_checksum
  );
  modport slave (
    output seg_valid, seg_base_addr, seg_len, seg_num_cims, seg_cim_addr,
    output ext_mem_data_valid, ext_mem_data, bus_ready,
    input  seg_ready, seg_done, ext_mem_rd, ext_mem_addr,
    input  bus_drive, bus_op_write, bus_data_write, bus_target_write,
    input  seg_checksum
  );
`else
  modport master (
    input  seg_valid, seg_base_addr, seg_len, seg_num_cims, seg_cim_addr,
    input  ext_mem_data_valid, ext_mem_data, bus_ready,
    output seg_ready, seg_done, ext_mem_rd, ext_mem_addr,
    output bus_drive, bus_op_write, bus_data_write, bus_target_write
  );
  modport slave (
    output seg_valid, seg_base_addr, seg_len, seg_num_cims, seg_cim_addr,
    output ext_mem_data_valid, ext_mem_data, bus_ready,
    input  seg_ready, seg_done, ext_mem_rd, ext_mem_addr,
    input  bus_drive, bus_op_write, bus_data_write, bus_target_write
  );
`endif
endinterface

// File: rtl/param_stream_loader.sv
// param_stream_loader
//   Accepts one segment descriptor at a time, reads seg_len parameter words
//   per CiM from external memory (one read outstanding), packs WORDS_PER_OP
//   words per bus op and streams them to CiMs 0 .. seg_num_cims-1. Each CiM
//   gets a DATA_STREAM_START op (data[0]=cim_addr, data[1]=len) followed by
//   DATA_STREAM ops; the last pack of a CiM is zero-padded.
//
//   Ports:
//     clk, rst   : clock, synchronous active-high reset
//     io         : param_stream_loader_if.master (descriptor, memory, bus)
//     dbg_state  : current FSM state (IDLE=0 START=1 FETCH=2 WAIT=3 SEND=4
//                  NEXT_CIM=5 DONE=6)
//
//   Optional feature macro: PARAM_STREAM_CHECKSUM_EN adds io.seg_checksum,
//   the signed sum of every word accepted in the current segment.
module param_stream_loader #(
  parameter int NUM_CIMS     = 64,
  parameter int N_STORAGE    = 16,
  parameter int WORDS_PER_OP = 3,
  parameter int ADDR_W       = 15,
  parameter int LEN_W        = 8,
  parameter int BUS_OP_WIDTH = 4,
  parameter logic [BUS_OP_WIDTH-1:0] NOP_OP               = '0,
  parameter logic [BUS_OP_WIDTH-1:0] DATA_STREAM_START_OP = BUS_OP_WIDTH'(5),
  parameter logic [BUS_OP_WIDTH-1:0] DATA_STREAM_OP       = BUS_OP_WIDTH'(6)
) (
  input  logic                   clk,
  input  logic                   rst,
  param_stream_loader_if.master  io,
  output logic [2:0]             dbg_state
);
  localparam int CW  = $clog2(NUM_CIMS);
  localparam int WIW = $clog2(WORDS_PER_OP);
  localparam int PW  = WORDS_PER_OP * N_STORAGE;
  localparam logic [CW:0] MAX_CIMS = (CW+1)'(NUM_CIMS);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_FETCH, S_WAIT, S_SEND, S_NEXT_CIM, S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [LEN_W-1:0]     len_q, len_d;
  logic [CW:0]          num_q, num_d;
  logic [LEN_W-1:0]     cim_addr_q, cim_addr_d;
  logic [CW-1:0]        cim_idx_q, cim_idx_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [LEN_W-1:0]     elem_cnt_q, elem_cnt_d;
  logic [WIW-1:0]       word_idx_q, word_idx_d;
  logic [N_STORAGE-1:0] pack_q [WORDS_PER_OP];
  logic [N_STORAGE-1:0] pack_d [WORDS_PER_OP];
  logic [PW-1:0]        data_hold_q, data_hold_d;
  logic [CW-1:0]        target_hold_q, target_hold_d;
  logic [PW-1:0]        payload;
  logic                 accept, drive, pack_full, cim_last_elem;
  logic [LEN_W-1:0]     elem_next;

  assign accept        = (state_q == S_IDLE) && io.seg_valid;
  // bus_ready is used combinationally so an op goes out in the same cycle
  // the bus becomes free.
  assign drive         = ((state_q == S_START) || (state_q == S_SEND)) && io.bus_ready;
  assign elem_next     = elem_cnt_q + LEN_W'(1);
  assign pack_full     = (word_idx_q == WIW'(WORDS_PER_OP - 1));
  assign cim_last_elem = (elem_next == len_q);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (io.seg_valid) begin
        if ((io.seg_len == '0) || (io.seg_num_cims == '0)) state_d = S_DONE;
        else                                                state_d = S_START;
      end
      S_START: if (io.bus_ready) state_d = S_FETCH;
      S_FETCH: state_d = S_WAIT;
      S_WAIT: if (io.ext_mem_data_valid) begin
        if (pack_full || cim_last_elem) state_d = S_SEND;
        else                            state_d = S_FETCH;
      end
      S_SEND: if (io.bus_ready) begin
        if (elem_cnt_q == len_q) state_d = S_NEXT_CIM;
        else                     state_d = S_FETCH;
      end
      S_NEXT_CIM: begin
        if (({1'b0, cim_idx_q} + (CW+1)'(1)) == num_q) state_d = S_DONE;
        else                                            state_d = S_START;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next values
  always_comb begin
    len_d         = len_q;
    num_d         = num_q;
    cim_addr_d    = cim_addr_q;
    cim_idx_d     = cim_idx_q;
    addr_d        = addr_q;
    elem_cnt_d    = elem_cnt_q;
    word_idx_d    = word_idx_q;
    pack_d        = pack_q;
    data_hold_d   = data_hold_q;
    target_hold_d = target_hold_q;

    if (accept) begin
      len_d      = io.seg_len;
      num_d      = (io.seg_num_cims > MAX_CIMS) ? MAX_CIMS : io.seg_num_cims;
      cim_addr_d = io.seg_cim_addr;
      cim_idx_d  = '0;
      addr_d     = io.seg_base_addr;
      elem_cnt_d = '0;
      word_idx_d = '0;
    end
    if ((state_q == S_START) && io.bus_ready) begin
      elem_cnt_d = '0;
      word_idx_d = '0;
    end
    if ((state_q == S_WAIT) && io.ext_mem_data_valid) begin
      pack_d[word_idx_q] = io.ext_mem_data;
      addr_d             = addr_q + ADDR_W'(1);
      elem_cnt_d         = elem_next;
      if (!(pack_full || cim_last_elem)) word_idx_d = word_idx_q + WIW'(1);
    end
    if ((state_q == S_SEND) && io.bus_ready) begin
      // Cleared after every send so a short final pack carries zeros.
      for (int i = 0; i < WORDS_PER_OP; i++) pack_d[i] = '0;
      word_idx_d = '0;
    end
    if (state_q == S_NEXT_CIM) cim_idx_d = cim_idx_q + CW'(1);
    if (drive) begin
      data_hold_d   = payload;
      target_hold_d = cim_idx_q;
    end
  end

  always_comb begin
    payload = '0;
    if (state_q == S_START) begin
      payload[0 +: N_STORAGE]         = N_STORAGE'(cim_addr_q);
      payload[N_STORAGE +: N_STORAGE] = N_STORAGE'(len_q);
    end else begin
      for (int i = 0; i < WORDS_PER_OP; i++) payload[i*N_STORAGE +: N_STORAGE] = pack_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len_q         <= '0;
      num_q         <= '0;
      cim_addr_q    <= '0;
      cim_idx_q     <= '0;
      addr_q        <= '0;
      elem_cnt_q    <= '0;
      word_idx_q    <= '0;
      data_hold_q   <= '0;
      target_hold_q <= '0;
      for (int i = 0; i < WORDS_PER_OP; i++) pack_q[i] <= '0;
    end else begin
      len_q         <= len_d;
      num_q         <= num_d;
      cim_addr_q    <= cim_addr_d;
      cim_idx_q     <= cim_idx_d;
      addr_q        <= addr_d;
      elem_cnt_q    <= elem_cnt_d;
      word_idx_q    <= word_idx_d;
      data_hold_q   <= data_hold_d;
      target_hold_q <= target_hold_d;
      pack_q        <= pack_d;
    end
  end

  // Output logic; payload/target are shown live while driving and held after.
  always_comb begin
    io.seg_ready        = (state_q == S_IDLE);
    io.seg_done         = (state_q == S_DONE);
    io.ext_mem_rd       = (state_q == S_FETCH);
    io.ext_mem_addr     = addr_q;
    io.bus_drive        = drive;
    io.bus_op_write     = NOP_OP;
    if (drive) io.bus_op_write = (state_q == S_START) ? DATA_STREAM_START_OP : DATA_STREAM_OP;
    io.bus_data_write   = drive ? payload : data_hold_q;
    io.bus_target_write = drive ? cim_idx_q : target_hold_q;
    dbg_state           = state_q;
  end

`ifdef PARAM_STREAM_CHECKSUM_EN
  localparam int CSW = N_STORAGE + LEN_W + CW;
  logic [CSW-1:0] checksum_q, checksum_d;

  always_comb begin
    checksum_d = checksum_q;
    if (accept) checksum_d = '0;
    else if ((state_q == S_WAIT) && io.ext_mem_data_valid)
      checksum_d = checksum_q + {{(CSW-N_STORAGE){io.ext_mem_data[N_STORAGE-1]}}, io.ext_mem_data};
  end

  always_ff @(posedge clk) begin
    if (rst) checksum_q <= '0;
    else     checksum_q <= checksum_d;
  end

  assign io.seg_checksum = checksum_q;
`endif
endmodule

// File: tb/tb_param_stream_loader.sv
// Directed testbench for param_stream_loader: a latency-programmable memory
// responder returns data = address (or an override table), a monitor records
// every bus op, and the main sequence compares them to hand-built op lists.
module tb_param_stream_loader;
  localparam int NUM_CIMS = 64, N_STORAGE = 16, WORDS_PER_OP = 3;
  localparam int ADDR_W = 15, LEN_W = 8, BUS_OP_WIDTH = 4;
  localparam logic [3:0] NOP = 4'd0, OP_START = 4'd5, OP_DATA = 4'd6;
  localparam int RW = 4 + 6 + 3 * 16;

  // Clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  param_stream_loader_if #(.NUM_CIMS(NUM_CIMS), .N_STORAGE(N_STORAGE),
    .WORDS_PER_OP(WORDS_PER_OP), .ADDR_W(ADDR_W), .LEN_W(LEN_W),
    .BUS_OP_WIDTH(BUS_OP_WIDTH)) io ();
  logic [2:0] dbg_state;

  param_stream_loader #(.NUM_CIMS(NUM_CIMS), .N_STORAGE(N_STORAGE),
    .WORDS_PER_OP(WORDS_PER_OP), .ADDR_W(ADDR_W), .LEN_W(LEN_W),
    .BUS_OP_WIDTH(BUS_OP_WIDTH)) dut (.clk(clk), .rst(rst), .io(io), .dbg_state(dbg_state));

  // Scoreboard state
  logic [RW-1:0] exp_q[$];
  logic [RW-1:0] got_q[$];
  int checks = 0, passed = 0, fails = 0;
  int nop_err = 0, addr_err = 0, ost_err = 0, rd_cnt = 0, drv_cnt = 0, done_cnt = 0;
  logic [ADDR_W-1:0] exp_rd_addr = '0;

  // Memory responder
  int mem_lat = 1;
  int mem_cnt = 0;
  logic [ADDR_W-1:0] mem_addr;
  logic mem_valid = 1'b0, spur_valid = 1'b0;
  logic [15:0] mem_data = '0;
  logic [15:0] mem_override [int];

  assign io.ext_mem_data_valid = mem_valid | spur_valid;
  assign io.ext_mem_data       = spur_valid ? 16'hDEAD : mem_data;

  function automatic logic [15:0] mem_word(input logic [ADDR_W-1:0] a);
    if (mem_override.exists(int'(a))) return mem_override[int'(a)];
    return 16'(a);
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      mem_valid = 1'b0;
      if (rst) mem_cnt = 0;
      else if (io.ext_mem_rd) begin
        if (mem_cnt != 0) ost_err++;
        mem_addr = io.ext_mem_addr;
        mem_cnt  = mem_lat;
      end else if (mem_cnt > 0) begin
        mem_cnt--;
        if (mem_cnt == 0) begin
          mem_valid = 1'b1;
          mem_data  = mem_word(mem_addr);
        end
      end
    end
  end

  // Bus / memory monitor (samples 1 time unit after the falling edge)
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (!rst) begin
        if (io.bus_drive) begin
          got_q.push_back({io.bus_op_write, io.bus_target_write, io.bus_data_write});
          drv_cnt++;
        end else if (io.bus_op_write !== NOP) nop_err++;
        if (io.seg_done) done_cnt++;
        if (io.ext_mem_rd) begin
          rd_cnt++;
          if (io.ext_mem_addr !== exp_rd_addr) addr_err++;
          exp_rd_addr = exp_rd_addr + 1'b1;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [RW-1:0] mk(input logic [3:0] op, input int t,
                                       input logic [15:0] d0, d1, d2);
    return {op, 6'(t), d2, d1, d0};
  endfunction

  // Driver tasks
  task automatic clr();
    nop_err = 0; addr_err = 0; ost_err = 0; rd_cnt = 0; drv_cnt = 0; done_cnt = 0;
    got_q.delete();
  endtask

  task automatic run_seg(input logic [14:0] base, input logic [7:0] len,
                         input logic [6:0] num, input logic [7:0] caddr);
    @(negedge clk);
    io.seg_valid = 1'b1; io.seg_base_addr = base; io.seg_len = len;
    io.seg_num_cims = num; io.seg_cim_addr = caddr;
    exp_rd_addr = base;
    @(negedge clk);
    io.seg_valid = 1'b0;
  endtask

  // Returns the index of the cycle after the accepting edge that shows seg_done.
  task automatic wait_done(input string tag, input int budget, output int n);
    n = 1;
    #2;
    while (!io.seg_done && n < budget) begin
      @(negedge clk);
      #2;
      n++;
    end
    check({tag, "_done_seen"}, 64'(io.seg_done), 64'd1);
  endtask

  task automatic compare_ops(input string tag);
    logic [RW-1:0] e, g;
    check({tag, "_op_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : {RW{1'bx}};
      check($sformatf("%s_op%0d", tag, i), 64'(g), 64'(e));
    end
    got_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_seg_ready"}, 64'(io.seg_ready), 64'd1);
    check({tag, "_seg_done"},  64'(io.seg_done), 64'd0);
    check({tag, "_mem_rd"},    64'(io.ext_mem_rd), 64'd0);
    check({tag, "_mem_addr"},  64'(io.ext_mem_addr), 64'd0);
    check({tag, "_bus_drive"}, 64'(io.bus_drive), 64'd0);
    check({tag, "_bus_op"},    64'(io.bus_op_write), 64'(NOP));
    check({tag, "_bus_data"},  64'(io.bus_data_write), 64'd0);
    check({tag, "_bus_tgt"},   64'(io.bus_target_write), 64'd0);
    check({tag, "_state"},     64'(dbg_state), 64'd0);
`ifdef PARAM_STREAM_CHECKSUM_EN
    check({tag, "_checksum"},  64'(io.seg_checksum), 64'd0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Directed sequence
  initial begin
    int n;
    int i;
    rst = 1'b1;
    io.seg_valid = 1'b0; io.seg_base_addr = '0; io.seg_len = '0;
    io.seg_num_cims = '0; io.seg_cim_addr = '0; io.bus_ready = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    // 1: two CiMs, len 5, zero-stall bus, 1-cycle memory
    clr();
    exp_q.push_back(mk(OP_START, 0, 16'd7, 16'd5, 16'd0));
    exp_q.push_back(mk(OP_DATA, 0, 16'd100, 16'd101, 16'd102));
    exp_q.push_back(mk(OP_DATA, 0, 16'd103, 16'd104, 16'd0));
    exp_q.push_back(mk(OP_START, 1, 16'd7, 16'd5, 16'd0));
    exp_q.push_back(mk(OP_DATA, 1, 16'd105, 16'd106, 16'd107));
    exp_q.push_back(mk(OP_DATA, 1, 16'd108, 16'd109, 16'd0));
    run_seg(15'd100, 8'd5, 7'd2, 8'd7);
    #1;
    check("t1_busy_not_ready", 64'(io.seg_ready), 64'd0);
    wait_done("t1", 200, n);
    check("t1_cycles", 64'(n), 64'd29);
    repeat (3) @(negedge clk);
    #2;
    check("t1_done_pulses", 64'(done_cnt), 64'd1);
    check("t1_rd_count", 64'(rd_cnt), 64'd10);
    check("t1_addr_seq", 64'(addr_err), 64'd0);
    check("t1_nop_idle", 64'(nop_err), 64'd0);
    compare_ops("t1");

    // 2: bus_ready low while the single pack waits in SEND
    clr();
    exp_q.push_back(mk(OP_START, 0, 16'd4, 16'd3, 16'd0));
    exp_q.push_back(mk(OP_DATA, 0, 16'd200, 16'd201, 16'd202));
    run_seg(15'd200, 8'd3, 7'd1, 8'd4);
    i = 0;
    while (rd_cnt < 3 && i < 50) begin
      @(negedge clk);
      #2;
      i++;
    end
    check("t2_reads_seen", 64'(rd_cnt), 64'd3);
    @(negedge clk);
    io.bus_ready = 1'b0;
    n = drv_cnt;
    repeat (10) @(negedge clk);
    #2;
    check("t2_stall_no_drive", 64'(drv_cnt - n), 64'd0);
    check("t2_stall_nop", 64'(nop_err), 64'd0);
    check("t2_stall_state", 64'(dbg_state), 64'd4);
    @(negedge clk);
    io.bus_ready = 1'b1;
    #2;
    check("t2_rise_drive", 64'(io.bus_drive), 64'd1);
    check("t2_rise_op", 64'(io.bus_op_write), 64'(OP_DATA));
    check("t2_rise_data", 64'(io.bus_data_write), {16'd0, 16'd202, 16'd201, 16'd200});
    wait_done("t2", 50, n);
    repeat (2) @(negedge clk);
    #2;
    check("t2_done_pulses", 64'(done_cnt), 64'd1);
    compare_ops("t2");

    // 3: zero-length segment
    clr();
    run_seg(15'd500, 8'd0, 7'd4, 8'd1);
    wait_done("t3", 10, n);
    check("t3_cycles", 64'(n), 64'd1);
    @(negedge clk);
    #2;
    check("t3_done_cleared", 64'(io.seg_done), 64'd0);
    check("t3_ready_back", 64'(io.seg_ready), 64'd1);
    repeat (2) @(negedge clk);
    #2;
    check("t3_no_reads", 64'(rd_cnt), 64'd0);
    check("t3_no_drive", 64'(drv_cnt), 64'd0);
    check("t3_done_pulses", 64'(done_cnt), 64'd1);

    // 4: 4-cycle memory, spurious valid while idle
    clr();
    mem_lat = 4;
    @(negedge clk);
    spur_valid = 1'b1;
    @(negedge clk);
    spur_valid = 1'b0;
    #2;
    check("t4_spur_idle", 64'(dbg_state), 64'd0);
    exp_q.push_back(mk(OP_START, 0, 16'd2, 16'd4, 16'd0));
    exp_q.push_back(mk(OP_DATA, 0, 16'd300, 16'd301, 16'd302));
    exp_q.push_back(mk(OP_DATA, 0, 16'd303, 16'd0, 16'd0));
    run_seg(15'd300, 8'd4, 7'd1, 8'd2);
    wait_done("t4", 200, n);
    check("t4_cycles", 64'(n), 64'd25);
    check("t4_rd_count", 64'(rd_cnt), 64'd4);
    check("t4_addr_seq", 64'(addr_err), 64'd0);
    check("t4_outstanding", 64'(ost_err), 64'd0);
    compare_ops("t4");

    // 5: address wrap at the top of memory
    clr();
    mem_lat = 1;
    exp_q.push_back(mk(OP_START, 0, 16'd0, 16'd3, 16'd0));
    exp_q.push_back(mk(OP_DATA, 0, 16'h7FFE, 16'h7FFF, 16'h0000));
    run_seg(15'd32766, 8'd3, 7'd1, 8'd0);
    wait_done("t5", 50, n);
    check("t5_cycles", 64'(n), 64'd10);
    check("t5_addr_seq", 64'(addr_err), 64'd0);
    compare_ops("t5");

    // 6: seg_num_cims above NUM_CIMS is clamped
    clr();
    for (int k = 0; k < 64; k++) begin
      exp_q.push_back(mk(OP_START, k, 16'd3, 16'd1, 16'd0));
      exp_q.push_back(mk(OP_DATA, k, 16'(1000 + k), 16'd0, 16'd0));
    end
    run_seg(15'd1000, 8'd1, 7'd100, 8'd3);
    wait_done("t6", 1000, n);
    check("t6_cycles", 64'(n), 64'd321);
    check("t6_addr_seq", 64'(addr_err), 64'd0);
    compare_ops("t6");

    // 7: reset while the second CiM is stalled in SEND, then a fresh segment
    clr();
    run_seg(15'd100, 8'd5, 7'd2, 8'd7);
    i = 0;
    while (got_q.size() < 4 && i < 100) begin
      @(negedge clk);
      #2;
      i++;
    end
    check("t7_second_start", 64'(got_q.size()), 64'd4);
    @(negedge clk);
    io.bus_ready = 1'b0;
    repeat (10) @(negedge clk);
    #2;
    check("t7_stalled_send", 64'(dbg_state), 64'd4);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #2;
    check_reset_outputs("t7_rst");
    @(negedge clk);
    rst = 1'b0;
    io.bus_ready = 1'b1;
    spur_valid = 1'b1;
    @(negedge clk);
    spur_valid = 1'b0;
    #2;
    check("t7_spur_idle", 64'(dbg_state), 64'd0);
    clr();
    exp_q.push_back(mk(OP_START, 0, 16'd9, 16'd2, 16'd0));
    exp_q.push_back(mk(OP_DATA, 0, 16'd50, 16'd51, 16'd0));
    run_seg(15'd50, 8'd2, 7'd1, 8'd9);
    wait_done("t7", 50, n);
    check("t7_cycles", 64'(n), 64'd8);
    repeat (2) @(negedge clk);
    #2;
    check("t7_done_pulses", 64'(done_cnt), 64'd1);
    compare_ops("t7");

`ifdef PARAM_STREAM_CHECKSUM_EN
    // 8: signed checksum of {-3, 4, 10}
    clr();
    mem_override[400] = 16'hFFFD;
    mem_override[401] = 16'd4;
    mem_override[402] = 16'd10;
    run_seg(15'd400, 8'd3, 7'd1, 8'd0);
    wait_done("t8", 50, n);
    check("t8_checksum_done", 64'(io.seg_checksum), 64'd11);
    repeat (3) @(negedge clk);
    #2;
    check("t8_checksum_hold", 64'(io.seg_checksum), 64'd11);
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
